// File: rtl/aes_key192_sched_ctrl_pkg.sv
// AES-192 key schedule controller: shared types and constants.
// Used by the controller top and the round-key buffer.
package aes_key192_sched_ctrl_pkg;

  localparam int AES192_NUM_RK   = 13;
  localparam int AES192_LAST_CNT = 12;
  localparam int AES_RK_W        = 128;

  typedef enum logic [2:0] {
    IDLE,
    START,
    EXPAND,
    READY,
    FAULT
  } state_e;

endpackage

// File: rtl/aes_key192_sched_ctrl_rkey_buf.sv
// Round-key storage: NUM_RK x 128 registers, one write port, one registered read port.
// With AES_RKEY_ZEROIZE_EN the entries are also cleared by reset.
module aes_rkey_buf
  import aes_key192_sched_ctrl_pkg::*;
#(
  parameter int NUM_RK = AES192_NUM_RK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [3:0]          waddr,
  input  logic [AES_RK_W-1:0] wdata,
  input  logic                clr,
  input  logic                re,
  input  logic [3:0]          raddr,
  output logic [AES_RK_W-1:0] rdata
);

  logic [AES_RK_W-1:0] mem_q [NUM_RK];
  logic [AES_RK_W-1:0] mem_d [NUM_RK];
  logic [AES_RK_W-1:0] rdata_q, rdata_d;

  // Next entry contents: a write to an entry wins over a bulk clear
  always_comb begin
    for (int i = 0; i < NUM_RK; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) mem_d[i] = '0;
      if (we && waddr == 4'(i)) mem_d[i] = wdata;
    end
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

`ifdef AES_RKEY_ZEROIZE_EN
  // Entry storage, zeroized on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RK; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`else
  // Entry storage, stale contents survive reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`endif

  // Registered read data, holds when no read is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/aes_key192_sched_ctrl.sv
// AES-192 key schedule controller: key load, expander sequencing, round-key reads.
// Optional AES_RKEY_ZEROIZE_EN clears the round-key buffer on reset, fault and key load.
module aes_key192_sched_ctrl
  import aes_key192_sched_ctrl_pkg::*;
#(
  parameter int NUM_RK      = AES192_NUM_RK,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [191:0]        key_in,
  output logic                key_ready,
  output logic                exp_start,
  output logic [191:0]        exp_key,
  input  logic [AES_RK_W-1:0] exp_subkey,
  input  logic [3:0]          exp_cnt,
  input  logic                exp_valid,
  input  logic                rk_req,
  input  logic [3:0]          rk_idx,
  output logic [AES_RK_W-1:0] rk_out,
  output logic                rk_ack,
  output logic                rk_err,
  output logic                keys_rdy,
  output logic                busy,
  output logic                exp_fault
);

  localparam int         CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST = 4'(NUM_RK - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [191:0]         exp_key_q, exp_key_d;
  logic                 keys_rdy_q, keys_rdy_d;
  logic                 fault_q, fault_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 buf_we;
  logic [3:0]           buf_waddr;
  logic [AES_RK_W-1:0]  buf_wdata;
  logic                 buf_clr;
  logic                 buf_re;

  assign key_ready = (state_q == IDLE) || (state_q == READY);
  assign busy      = (state_q == START) || (state_q == EXPAND);
  assign exp_start = (state_q == START);

  // Next state, timeout counter and buffer write selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_key_d  = exp_key_q;
    keys_rdy_d = keys_rdy_q;
    fault_d    = fault_q;
    buf_we     = 1'b0;
    buf_waddr  = 4'd0;
    buf_wdata  = exp_subkey;
    buf_clr    = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          exp_key_d  = key_in;
          buf_we     = 1'b1;
          buf_wdata  = key_in[191:64];
          keys_rdy_d = 1'b0;
          cnt_d      = '0;
          state_d    = START;
`ifdef AES_RKEY_ZEROIZE_EN
          buf_clr    = 1'b1;
`endif
        end
      end
      START: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = EXPAND;
      end
      EXPAND: begin
        cnt_d = cnt_q + 1'b1;
        if (exp_valid) begin
          if (exp_cnt != 4'd0 && exp_cnt <= LAST) begin
            buf_we    = 1'b1;
            buf_waddr = exp_cnt;
          end else begin
            fault_d = 1'b1;
          end
        end
        if (exp_valid && exp_cnt == LAST) begin
          state_d    = READY;
          keys_rdy_d = 1'b1;
        end else if (cnt_d == CW'(TIMEOUT_CYC)) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          keys_rdy_d = 1'b0;
`ifdef AES_RKEY_ZEROIZE_EN
          buf_clr    = 1'b1;
`endif
        end
      end
      FAULT: begin
        keys_rdy_d = 1'b0;
        fault_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read request qualification: only in READY with an in-range index
  always_comb begin
    buf_re = rk_req && (state_q == READY) && (rk_idx <= LAST);
    ack_d  = buf_re;
    err_d  = rk_req && !buf_re;
  end

  // Control and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      exp_key_q  <= '0;
      keys_rdy_q <= 1'b0;
      fault_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_key_q  <= exp_key_d;
      keys_rdy_q <= keys_rdy_d;
      fault_q    <= fault_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign exp_key   = exp_key_q;
  assign keys_rdy  = keys_rdy_q;
  assign exp_fault = fault_q;
  assign rk_ack    = ack_q;
  assign rk_err    = err_q;

  aes_rkey_buf #(
    .NUM_RK(NUM_RK)
  ) u_buf (
    .clk  (clk),
    .reset(reset),
    .we   (buf_we),
    .waddr(buf_waddr),
    .wdata(buf_wdata),
    .clr  (buf_clr),
    .re   (buf_re),
    .raddr(rk_idx),
    .rdata(rk_out)
  );

endmodule

// File: tb/tb_aes_key192_sched_ctrl.sv
// Directed testbench for aes_key192_sched_ctrl.
// Bench acts as key source, expander and round-key reader.
module tb_aes_key192_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [191:0] key_in;
  logic         key_ready;
  logic         exp_start;
  logic [191:0] exp_key;
  logic [127:0] exp_subkey;
  logic [3:0]   exp_cnt;
  logic         exp_valid;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_ack;
  logic         rk_err;
  logic         keys_rdy;
  logic         busy;
  logic         exp_fault;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FIPS_RK0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_RK12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [191:0] KEY2 = 192'hfedcba9876543210_0f1e2d3c4b5a6978_8899aabbccddeeff;
  localparam logic [127:0] SALT1 = 128'h0123456789abcdef0f1e2d3c4b5a6978;
  localparam logic [127:0] SALT2 = 128'hdeadbeefcafef00d5555aaaa12345678;

  always #5 clk = ~clk;

  aes_key192_sched_ctrl dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .exp_start(exp_start), .exp_key(exp_key), .exp_subkey(exp_subkey),
    .exp_cnt(exp_cnt), .exp_valid(exp_valid),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_out(rk_out),
    .rk_ack(rk_ack), .rk_err(rk_err),
    .keys_rdy(keys_rdy), .busy(busy), .exp_fault(exp_fault)
  );

  function automatic logic [127:0] sk(input int i, input logic [127:0] salt);
    logic [31:0] w;
    w = 32'(i);
    return {w, w, w, w} ^ salt;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [191:0] k);
    key_valid = 1'b1;
    key_in = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx);
    rk_req = 1'b1;
    rk_idx = idx;
    step();
    rk_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_valid = 0; key_in = '0; exp_subkey = '0; exp_cnt = '0;
    exp_valid = 0; rk_req = 0; rk_idx = '0;
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_key_ready got=%b exp=1", key_ready); end
    n_cmp++; if ({keys_rdy, busy, exp_fault, exp_start, rk_ack, rk_err} !== 6'b0) begin n_bad++; $display("FAIL rst_flags got=%b exp=000000", {keys_rdy, busy, exp_fault, exp_start, rk_ack, rk_err}); end
    n_cmp++; if (rk_out !== 128'h0) begin n_bad++; $display("FAIL rst_rk_out got=%h exp=0", rk_out); end
    n_cmp++; if (exp_key !== 192'h0) begin n_bad++; $display("FAIL rst_exp_key got=%h exp=0", exp_key); end
    rd(4'd0);
    n_cmp++; if ({rk_ack, rk_err} !== 2'b01) begin n_bad++; $display("FAIL idle_read ack/err got=%b exp=01", {rk_ack, rk_err}); end
  endtask

  task automatic test_fips();
    load_key(FIPS_KEY);
    n_cmp++; if ({exp_start, busy, key_ready, keys_rdy} !== 4'b1100) begin n_bad++; $display("FAIL start_flags got=%b exp=1100", {exp_start, busy, key_ready, keys_rdy}); end
    n_cmp++; if (exp_key !== FIPS_KEY) begin n_bad++; $display("FAIL exp_key got=%h exp=%h", exp_key, FIPS_KEY); end
    step();
    n_cmp++; if ({exp_start, busy} !== 2'b01) begin n_bad++; $display("FAIL expand_flags got=%b exp=01", {exp_start, busy}); end
    for (int i = 1; i <= 12; i++) begin
      exp_valid = 1'b1;
      exp_cnt = 4'(i);
      exp_subkey = (i == 12) ? FIPS_RK12 : sk(i, SALT1);
      step();
    end
    exp_valid = 1'b0;
    n_cmp++; if ({keys_rdy, busy, key_ready, exp_fault} !== 4'b1010) begin n_bad++; $display("FAIL done_flags got=%b exp=1010", {keys_rdy, busy, key_ready, exp_fault}); end
    rd(4'd0);
    n_cmp++; if (rk_out !== FIPS_RK0 || rk_ack !== 1'b1) begin n_bad++; $display("FAIL fips_rk0 got=%h ack=%b exp=%h ack=1", rk_out, rk_ack, FIPS_RK0); end
    rd(4'd12);
    n_cmp++; if (rk_out !== FIPS_RK12 || rk_ack !== 1'b1) begin n_bad++; $display("FAIL fips_rk12 got=%h ack=%b exp=%h ack=1", rk_out, rk_ack, FIPS_RK12); end
  endtask

  task automatic test_back_to_back();
    rk_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rk_idx = 4'(i);
      step();
      n_cmp++; if (rk_out !== sk(i, SALT1) || rk_ack !== 1'b1 || rk_err !== 1'b0) begin n_bad++; $display("FAIL b2b_rk%0d got=%h ack=%b err=%b exp=%h ack=1 err=0", i, rk_out, rk_ack, rk_err, sk(i, SALT1)); end
    end
    rk_req = 1'b0;
    step();
    n_cmp++; if (rk_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_ack got=%b exp=0", rk_ack); end
  endtask

  task automatic test_bad_read();
    rd(4'd5);
    rd(4'd13);
    n_cmp++; if ({rk_ack, rk_err} !== 2'b01) begin n_bad++; $display("FAIL bad_idx ack/err got=%b exp=01", {rk_ack, rk_err}); end
    n_cmp++; if (rk_out !== sk(5, SALT1)) begin n_bad++; $display("FAIL bad_idx_hold got=%h exp=%h", rk_out, sk(5, SALT1)); end
    rd(4'd12);
    n_cmp++; if ({rk_ack, rk_err} !== 2'b10 || rk_out !== FIPS_RK12) begin n_bad++; $display("FAIL after_bad rk12 got=%h ack/err=%b exp=%h 10", rk_out, {rk_ack, rk_err}, FIPS_RK12); end
  endtask

  task automatic test_exp_valid_outside();
    exp_valid = 1'b1;
    exp_cnt = 4'd4;
    exp_subkey = '1;
    step();
    exp_valid = 1'b0;
    n_cmp++; if ({keys_rdy, exp_fault} !== 2'b10) begin n_bad++; $display("FAIL outside_flags got=%b exp=10", {keys_rdy, exp_fault}); end
    rd(4'd4);
    n_cmp++; if (rk_out !== sk(4, SALT1)) begin n_bad++; $display("FAIL outside_rk4 got=%h exp=%h", rk_out, sk(4, SALT1)); end
  endtask

  task automatic test_reload();
    logic [127:0] want5;
    key_valid = 1'b1;
    key_in = KEY2;
    rk_req = 1'b1;
    rk_idx = 4'd3;
    step();
    key_valid = 1'b0;
    rk_req = 1'b0;
    n_cmp++; if (rk_out !== sk(3, SALT1) || rk_ack !== 1'b1) begin n_bad++; $display("FAIL reload_old_rk3 got=%h ack=%b exp=%h ack=1", rk_out, rk_ack, sk(3, SALT1)); end
    n_cmp++; if ({keys_rdy, busy, exp_start} !== 3'b011) begin n_bad++; $display("FAIL reload_flags got=%b exp=011", {keys_rdy, busy, exp_start}); end
    step();
    exp_valid = 1'b1;
    exp_cnt = 4'd0;
    exp_subkey = '1;
    step();
    n_cmp++; if ({exp_fault, busy} !== 2'b11) begin n_bad++; $display("FAIL bad_cnt0 fault/busy got=%b exp=11", {exp_fault, busy}); end
    exp_cnt = 4'd13;
    step();
    for (int i = 1; i <= 12; i++) begin
      exp_valid = (i != 5);
      exp_cnt = 4'(i);
      exp_subkey = sk(i, SALT2);
      step();
    end
    exp_valid = 1'b0;
    n_cmp++; if ({keys_rdy, busy} !== 2'b10) begin n_bad++; $display("FAIL reload_done got=%b exp=10", {keys_rdy, busy}); end
    rd(4'd0);
    n_cmp++; if (rk_out !== KEY2[191:64]) begin n_bad++; $display("FAIL reload_rk0 got=%h exp=%h", rk_out, KEY2[191:64]); end
    rd(4'd3);
    n_cmp++; if (rk_out !== sk(3, SALT2)) begin n_bad++; $display("FAIL reload_rk3 got=%h exp=%h", rk_out, sk(3, SALT2)); end
`ifdef AES_RKEY_ZEROIZE_EN
    want5 = '0;
`else
    want5 = sk(5, SALT1);
`endif
    rd(4'd5);
    n_cmp++; if (rk_out !== want5) begin n_bad++; $display("FAIL reload_rk5 got=%h exp=%h", rk_out, want5); end
  endtask

  task automatic test_reset_mid();
    load_key(FIPS_KEY);
    step();
    for (int i = 1; i <= 5; i++) begin
      exp_valid = 1'b1;
      exp_cnt = 4'(i);
      exp_subkey = sk(i, SALT1);
      step();
    end
    exp_valid = 1'b0;
    reset = 1'b1;
    #2;
    n_cmp++; if ({busy, key_ready, keys_rdy, exp_fault} !== 4'b0100) begin n_bad++; $display("FAIL async_reset got=%b exp=0100", {busy, key_ready, keys_rdy, exp_fault}); end
    step();
    reset = 1'b0;
    step(); step();
    n_cmp++; if ({busy, key_ready, keys_rdy, exp_start} !== 4'b0100) begin n_bad++; $display("FAIL post_reset got=%b exp=0100", {busy, key_ready, keys_rdy, exp_start}); end
    rd(4'd0);
    n_cmp++; if ({rk_ack, rk_err} !== 2'b01) begin n_bad++; $display("FAIL post_reset_read got=%b exp=01", {rk_ack, rk_err}); end
  endtask

  task automatic test_timeout();
    load_key(KEY2);
    for (int c = 2; c <= 32; c++) step();
    n_cmp++; if ({exp_fault, busy} !== 2'b01) begin n_bad++; $display("FAIL timeout_early got=%b exp=01", {exp_fault, busy}); end
    step();
    n_cmp++; if ({exp_fault, busy, key_ready, keys_rdy} !== 4'b1000) begin n_bad++; $display("FAIL timeout_fault got=%b exp=1000", {exp_fault, busy, key_ready, keys_rdy}); end
    key_valid = 1'b1;
    key_in = FIPS_KEY;
    step(); step();
    key_valid = 1'b0;
    n_cmp++; if ({exp_fault, exp_start, key_ready, busy} !== 4'b1000) begin n_bad++; $display("FAIL fault_sticky got=%b exp=1000", {exp_fault, exp_start, key_ready, busy}); end
    rd(4'd0);
    n_cmp++; if ({rk_ack, rk_err} !== 2'b01) begin n_bad++; $display("FAIL fault_read got=%b exp=01", {rk_ack, rk_err}); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_back_to_back();
    test_bad_read();
    test_exp_valid_outside();
    test_reload();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
